// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: services a cache miss by writing back a dirty victim line, then fetching the missing line word by word.
module cache_refill_ctrl #(
    parameter int TAG_W = 24,
    parameter int SET_W = 3,
    parameter int WORDS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss,
    input  logic [31:0]           miss_addr,
    input  logic                  victim_dirty,
    input  logic [TAG_W-1:0]      victim_tag,
    input  logic [32*WORDS-1:0]   victim_line,
    output logic                  busy,
    output logic                  fill_valid,
    output logic [32*WORDS-1:0]   fill_line,
    output logic [TAG_W-1:0]      fill_tag,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int OFF_W = IDX_W + 2;
    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
    state_t                r_state;
    logic [TAG_W-1:0]      r_tag;
    logic [TAG_W-1:0]      r_vtag;
    logic [SET_W-1:0]      r_set;
    logic [IDX_W-1:0]      r_idx;
    logic [32*WORDS-1:0]   r_victim;
    logic [32*WORDS-1:0]   r_line;
    logic [TAG_W-1:0]      r_fill_tag;
    logic                  r_busy;
    logic                  r_fill_valid;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [IDX_W-1:0]      w_nidx;
    logic                  w_last;
    logic [TAG_W-1:0]      w_cap_tag;
    logic [SET_W-1:0]      w_cap_set;
    assign w_nidx    = r_idx + IDX_W'(1);
    assign w_last    = r_idx == IDX_W'(WORDS - 1);
    assign w_cap_tag = miss_addr[OFF_W+SET_W +: TAG_W];
    assign w_cap_set = miss_addr[OFF_W +: SET_W];
    assign busy       = r_busy;
    assign fill_valid = r_fill_valid;
    assign fill_line  = r_line;
    assign fill_tag   = r_fill_tag;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    // Memory-port outputs are loaded one word ahead so they leave the flops with no input-to-output path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_tag        <= '0;
            r_vtag       <= '0;
            r_set        <= '0;
            r_idx        <= '0;
            r_victim     <= '0;
            r_line       <= '0;
            r_fill_tag   <= '0;
            r_busy       <= 1'b0;
            r_fill_valid <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_fill_valid <= 1'b0;
            case (r_state)
                IDLE: if (miss) begin
                    r_tag       <= w_cap_tag;
                    r_set       <= w_cap_set;
                    r_vtag      <= victim_tag;
                    r_victim    <= victim_line;
                    r_idx       <= '0;
                    r_busy      <= 1'b1;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= victim_dirty;
                    r_mem_addr  <= victim_dirty ? {victim_tag, w_cap_set, {IDX_W{1'b0}}, 2'b00}
                                                : {w_cap_tag, w_cap_set, {IDX_W{1'b0}}, 2'b00};
                    r_mem_wdata <= victim_dirty ? victim_line[31:0] : 32'd0;
                    r_state     <= victim_dirty ? WB : FILL;
                end
                WB: if (mem_ack) begin
                    if (w_last) begin
                        r_idx       <= '0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {r_tag, r_set, {IDX_W{1'b0}}, 2'b00};
                        r_mem_wdata <= 32'd0;
                        r_state     <= FILL;
                    end else begin
                        r_idx       <= w_nidx;
                        r_mem_addr  <= {r_vtag, r_set, w_nidx, 2'b00};
                        r_mem_wdata <= r_victim[{w_nidx, 5'd0} +: 32];
                    end
                end
                FILL: if (mem_ack) begin
                    r_line[{r_idx, 5'd0} +: 32] <= mem_rdata;
                    if (w_last) begin
                        r_idx        <= '0;
                        r_mem_req    <= 1'b0;
                        r_fill_valid <= 1'b1;
                        r_fill_tag   <= r_tag;
                        r_state      <= DONE;
                    end else begin
                        r_idx      <= w_nidx;
                        r_mem_addr <= {r_tag, r_set, w_nidx, 2'b00};
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed checks of clean, dirty, wait-state, ignored-miss, reset-abort and back-to-back refills.
module tb_cache_refill_ctrl;
    logic         clk = 1'b0;
    logic         reset;
    logic         miss;
    logic [31:0]  miss_addr;
    logic         victim_dirty;
    logic [23:0]  victim_tag;
    logic [255:0] victim_line;
    logic         busy;
    logic         fill_valid;
    logic [255:0] fill_line;
    logic [23:0]  fill_tag;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    int           n_chk = 0;
    int           n_fail = 0;
    logic [31:0]  wr_addr[$];
    logic [31:0]  wr_data[$];
    logic [31:0]  rd_addr[$];
    int           rd_cyc[$];
    int           fv_cyc[$];
    int           busy_low;
    int           we_cnt;
    logic [31:0]  dbase;
    logic [255:0] vline;

    cache_refill_ctrl dut (
        .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line),
        .busy(busy), .fill_valid(fill_valid), .fill_line(fill_line), .fill_tag(fill_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] b);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = b + 32'(i);
        return l;
    endfunction

    task automatic start_miss(input logic [31:0] a, input logic dirty, input logic [23:0] vt,
                              input logic [255:0] vl, input logic [31:0] db);
        @(negedge clk);
        miss = 1'b1; miss_addr = a; victim_dirty = dirty; victim_tag = vt; victim_line = vl;
        mem_ack = 1'b0; dbase = db;
        wr_addr.delete(); wr_data.delete(); rd_addr.delete(); rd_cyc.delete(); fv_cyc.delete();
        busy_low = 0; we_cnt = 0;
    endtask

    // Cycle k is the k-th clock period after the miss was sampled; the memory model acks every (waitn+1)-th requested cycle.
    task automatic serve(input int waitn, input int budget, input int n_fills, input bit keep_miss, input int pulse_cyc);
        int wcnt = 0;
        logic pend = 1'b0;
        logic [31:0] pa = '0, pw = '0;
        logic pwe = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            miss = keep_miss || (k == pulse_cyc);
            if (k == pulse_cyc) miss_addr = 32'h0000_5000;
            if (pend) begin
                chk("addr_hold", mem_addr, pa);
                chk("we_hold", mem_we, pwe);
                chk("wdata_hold", mem_wdata, pw);
            end
            if (!busy) busy_low++;
            if (mem_we) we_cnt++;
            if (fill_valid) fv_cyc.push_back(k);
            mem_ack = !mem_req;
            if (mem_req) begin
                if (wcnt == waitn) begin mem_ack = 1'b1; wcnt = 0; end
                else wcnt++;
            end
            mem_rdata = dbase + {29'd0, mem_addr[4:2]};
            if (mem_req && mem_ack) begin
                if (mem_we) begin wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata); end
                else begin rd_addr.push_back(mem_addr); rd_cyc.push_back(k); end
            end
            pend = mem_req && !mem_ack; pa = mem_addr; pwe = mem_we; pw = mem_wdata;
            if (fv_cyc.size() == n_fills) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; miss = 1'b0; miss_addr = '0; victim_dirty = 1'b0; victim_tag = '0;
        victim_line = '0; mem_ack = 1'b0; mem_rdata = '0; dbase = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fill_line", fill_line, 0);
        chk("rst_fill_tag", fill_tag, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        start_miss(32'h0000_1234, 1'b0, 24'h0, '0, 32'hA0);
        serve(0, 40, 1, 1'b0, 0);
        chk("clean_fills", fv_cyc.size(), 1);
        chk("clean_fv_cyc", fv_cyc[0], 9);
        chk("clean_we_never", we_cnt, 0);
        chk("clean_first_rd_cyc", rd_cyc[0], 1);
        chk("clean_rd_count", rd_addr.size(), 8);
        for (int i = 0; i < 8; i++) chk("clean_rd_addr", rd_addr[i], 32'h1220 + 32'(4*i));
        chk("clean_word0", fill_line[31:0], 32'hA0);
        chk("clean_word7", fill_line[255:224], 32'hA7);
        chk("clean_line", fill_line, mk_line(32'hA0));
        chk("clean_tag", fill_tag, 24'h000012);
        @(negedge clk);
        chk("clean_idle_busy", busy, 0);
        chk("clean_fv_pulse", fill_valid, 0);

        for (int i = 0; i < 8; i++) vline[32*i +: 32] = 32'h11 * 32'(i + 1);
        start_miss(32'h0000_3460, 1'b1, 24'h000012, vline, 32'hC0);
        serve(0, 60, 1, 1'b0, 0);
        chk("dirty_fv_cyc", fv_cyc[0], 17);
        chk("dirty_wr_count", wr_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("dirty_wr_addr", wr_addr[i], 32'h1260 + 32'(4*i));
            chk("dirty_wr_data", wr_data[i], 32'h11 * 32'(i + 1));
        end
        chk("dirty_rd_count", rd_addr.size(), 8);
        for (int i = 0; i < 8; i++) chk("dirty_rd_addr", rd_addr[i], 32'h3460 + 32'(4*i));
        chk("dirty_no_gap", rd_cyc[0], 9);
        chk("dirty_line", fill_line, mk_line(32'hC0));
        chk("dirty_tag", fill_tag, 24'h000034);

        start_miss(32'h0000_1234, 1'b0, 24'h0, '0, 32'h40);
        serve(2, 100, 1, 1'b0, 0);
        chk("wait_fv_cyc", fv_cyc[0], 25);
        chk("wait_rd_count", rd_addr.size(), 8);
        chk("wait_line", fill_line, mk_line(32'h40));

        start_miss(32'h0000_1234, 1'b0, 24'h0, '0, 32'hD0);
        serve(0, 40, 1, 1'b0, 3);
        chk("pulse_fv_cyc", fv_cyc[0], 9);
        chk("pulse_tag", fill_tag, 24'h000012);
        chk("pulse_line", fill_line, mk_line(32'hD0));
        serve(0, 4, 99, 1'b0, 0);
        chk("pulse_rd_count", rd_addr.size(), 8);
        chk("pulse_idle", busy_low, 4);

        start_miss(32'h0000_1234, 1'b0, 24'h0, '0, 32'hE0);
        serve(0, 4, 99, 1'b0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_acks", rd_addr.size(), 4);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_fill_line", fill_line, 0);
        @(negedge clk);
        reset = 1'b1;
        start_miss(32'h0000_7700, 1'b0, 24'h0, '0, 32'hB0);
        serve(0, 40, 1, 1'b0, 0);
        chk("rerun_fv_cyc", fv_cyc[0], 9);
        chk("rerun_first_addr", rd_addr[0], 32'h7700);
        chk("rerun_rd_count", rd_addr.size(), 8);
        chk("rerun_line", fill_line, mk_line(32'hB0));
        chk("rerun_tag", fill_tag, 24'h000077);

        start_miss(32'h0000_2040, 1'b0, 24'h0, '0, 32'h90);
        serve(0, 60, 2, 1'b1, 0);
        miss = 1'b0;
        chk("held_fills", fv_cyc.size(), 2);
        chk("held_fv1", fv_cyc[0], 9);
        chk("held_fv2", fv_cyc[1], 19);
        chk("held_busy_low", busy_low, 1);
        chk("held_rd_count", rd_addr.size(), 16);
        chk("held_second_start", rd_cyc[8], 11);
        chk("held_line", fill_line, mk_line(32'h90));
        chk("held_tag", fill_tag, 24'h000020);
        serve(0, 3, 99, 1'b0, 0);
        chk("held_drain_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
